// File: rtl/ctrl_sequencer_if.sv
// Signal bundle between the control sequencer and the fetch/decode/execute datapath.
// master: sequencer side; slave: environment (memory, decoder, function units).
interface ctrl_sequencer_if #(
  parameter int NUM_FUNC = 5,
  parameter int FUNC_W   = 3
);
  logic                fetch_ack;
  logic [FUNC_W-1:0]   func;
  logic                halt;
  logic [NUM_FUNC-1:0] unit_done;
  logic                branch_taken;
  logic                resume;
  logic                fault_clr;

  logic [7:0]          state;
  logic                fetch_req;
  logic [NUM_FUNC-1:0] exec_en;
  logic                pc_inc;
  logic                pc_load;
  logic                fault;
  logic [1:0]          fault_code;
  logic [31:0]         cyc_cnt;
  logic [31:0]         instr_cnt;

  modport master (
    input  fetch_ack, func, halt, unit_done, branch_taken, resume, fault_clr,
    output state, fetch_req, exec_en, pc_inc, pc_load, fault, fault_code,
           cyc_cnt, instr_cnt
  );

  modport slave (
    output fetch_ack, func, halt, unit_done, branch_taken, resume, fault_clr,
    input  state, fetch_req, exec_en, pc_inc, pc_load, fault, fault_code,
           cyc_cnt, instr_cnt
  );
endinterface

// File: rtl/ctrl_sequencer.sv
// One-hot Moore control sequencer: fetch/decode/execute with handshaked units, timeouts,
// branch PC load, halt/resume and sticky fault. Define SEQ_PERF_CNT_EN for cycle/instr counters.
module ctrl_sequencer #(
  parameter int                  NUM_FUNC   = 5,
  parameter int                  FUNC_W     = 3,
  parameter logic [NUM_FUNC-1:0] MULTI_MASK = 5'b10100,
  parameter int                  TMO_W      = 8,
  parameter int                  TMO_CYCLES = 200
) (
  input  logic            clk,
  input  logic            rst,
  ctrl_sequencer_if.master bus
);

  typedef enum logic [7:0] {
    S_INIT   = 8'h01,
    S_FETCH  = 8'h02,
    S_DECODE = 8'h04,
    S_EXEC   = 8'h08,
    S_INCPC  = 8'h10,
    S_LOADPC = 8'h20,
    S_HALT   = 8'h40,
    S_FAULT  = 8'h80
  } state_t;

  localparam logic [1:0] FC_NONE  = 2'd0;
  localparam logic [1:0] FC_ILLEG = 2'd1;
  localparam logic [1:0] FC_FTMO  = 2'd2;
  localparam logic [1:0] FC_XTMO  = 2'd3;

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TMO_CYCLES - 1);

  state_t              state_q;
  state_t              state_nxt;
  logic [FUNC_W-1:0]   func_q;
  logic                func_ld;
  logic [TMO_W-1:0]    timer_q;
  logic [1:0]          fault_code_q;
  logic [1:0]          fault_code_nxt;
  logic                exec_multi;
  logic                exec_done;
  logic                tmo_hit;
  logic                func_legal;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_INIT;
      func_q       <= '0;
      timer_q      <= '0;
      fault_code_q <= FC_NONE;
    end else begin
      state_q      <= state_nxt;
      fault_code_q <= fault_code_nxt;
      if (func_ld) begin
        func_q <= bus.func;
      end
      // The wait timer restarts on every transition and only runs while parked
      // in FETCH or a waiting EXEC; it saturates so it can never wrap to zero.
      if (state_nxt != state_q) begin
        timer_q <= '0;
      end else if ((state_q == S_FETCH || state_q == S_EXEC) && (timer_q != '1)) begin
        timer_q <= timer_q + TMO_W'(1);
      end
    end
  end

  always_comb begin
    exec_multi = MULTI_MASK[func_q];
    exec_done  = !exec_multi || bus.unit_done[func_q];
    tmo_hit    = (timer_q == TMO_LIMIT);
    func_legal = (bus.func != '0) && (int'(bus.func) < NUM_FUNC);
  end

  always_comb begin
    state_nxt      = state_q;
    fault_code_nxt = fault_code_q;
    func_ld        = 1'b0;
    unique case (state_q)
      S_INIT: begin
        state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (bus.fetch_ack) begin
          state_nxt = S_DECODE;
        end else if (tmo_hit) begin
          state_nxt      = S_FAULT;
          fault_code_nxt = FC_FTMO;
        end
      end
      S_DECODE: begin
        if (bus.halt) begin
          state_nxt = S_HALT;
        end else if (!func_legal) begin
          state_nxt      = S_FAULT;
          fault_code_nxt = FC_ILLEG;
        end else begin
          func_ld   = 1'b1;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        // A done arriving in the limit cycle takes precedence over the timeout.
        if (exec_done) begin
          state_nxt = bus.branch_taken ? S_LOADPC : S_INCPC;
        end else if (tmo_hit) begin
          state_nxt      = S_FAULT;
          fault_code_nxt = FC_XTMO;
        end
      end
      S_INCPC, S_LOADPC: begin
        state_nxt = S_FETCH;
      end
      S_HALT: begin
        if (bus.resume) begin
          state_nxt = S_INCPC;
        end
      end
      S_FAULT: begin
        if (bus.fault_clr) begin
          state_nxt      = S_INIT;
          fault_code_nxt = FC_NONE;
        end
      end
      default: begin
        state_nxt      = S_INIT;
        fault_code_nxt = FC_NONE;
      end
    endcase
  end

  always_comb begin
    bus.state      = state_q;
    bus.fetch_req  = (state_q == S_FETCH);
    bus.exec_en    = (state_q == S_EXEC) ? (NUM_FUNC'(1) << func_q) : '0;
    bus.pc_inc     = (state_q == S_INCPC);
    bus.pc_load    = (state_q == S_LOADPC);
    bus.fault      = (state_q == S_FAULT);
    bus.fault_code = fault_code_q;
  end

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cyc_cnt_q;
  logic [31:0] instr_cnt_q;

  // Counters survive fault_clr; only the hardware reset zeroes them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_cnt_q   <= '0;
      instr_cnt_q <= '0;
    end else begin
      if (!(state_q == S_INIT || state_q == S_HALT || state_q == S_FAULT)) begin
        cyc_cnt_q <= cyc_cnt_q + 32'd1;
      end
      if (state_q == S_INCPC || state_q == S_LOADPC) begin
        instr_cnt_q <= instr_cnt_q + 32'd1;
      end
    end
  end

  assign bus.cyc_cnt   = cyc_cnt_q;
  assign bus.instr_cnt = instr_cnt_q;
`else
  assign bus.cyc_cnt   = '0;
  assign bus.instr_cnt = '0;
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: a vector table for the main instruction flow
// plus hand-written sequences for timeouts, reset aborts and the perf counters.
module tb_ctrl_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  ctrl_sequencer_if #(.NUM_FUNC(5), .FUNC_W(3)) bus ();

  ctrl_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ack;
    logic [2:0] func;
    logic       halt;
    logic [4:0] done;
    logic       br;
    logic       res;
    logic       clr;
    logic [7:0] st;
    logic [4:0] en;
    logic [1:0] code;
  } vec_t;

  vec_t tbl[$];

`ifdef SEQ_PERF_CNT_EN
  localparam logic [31:0] EXP_CYC   = 32'd40;
  localparam logic [31:0] EXP_INSTR = 32'd10;
`else
  localparam logic [31:0] EXP_CYC   = 32'd0;
  localparam logic [31:0] EXP_INSTR = 32'd0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input logic ack, input logic [2:0] func, input logic halt,
                     input logic [4:0] done, input logic br, input logic res,
                     input logic clr, input logic [7:0] st, input logic [4:0] en,
                     input logic [1:0] code);
    vec_t v;
    v.ack = ack; v.func = func; v.halt = halt; v.done = done; v.br = br;
    v.res = res; v.clr = clr; v.st = st; v.en = en; v.code = code;
    tbl.push_back(v);
  endtask

  task automatic quiet();
    bus.fetch_ack = 1'b0; bus.func = 3'd0; bus.halt = 1'b0; bus.unit_done = 5'b0;
    bus.branch_taken = 1'b0; bus.resume = 1'b0; bus.fault_clr = 1'b0;
  endtask

  logic [3:0] exp_ctl;
  logic [3:0] act_ctl;
  int         n;

  initial begin
    checks   = 0;
    failures = 0;
    quiet();
    rst = 1'b0;

    // inputs -> expected outputs of the state current during that cycle
    add(1'b1, 3'd1, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h01, 5'b00000, 2'd0);
    add(1'b1, 3'd1, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h02, 5'b00000, 2'd0);
    add(1'b1, 3'd1, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h04, 5'b00000, 2'd0);
    add(1'b1, 3'd1, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h08, 5'b00010, 2'd0);
    add(1'b1, 3'd1, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h10, 5'b00000, 2'd0);
    add(1'b1, 3'd1, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h02, 5'b00000, 2'd0);
    add(1'b1, 3'd1, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h04, 5'b00000, 2'd0);
    add(1'b1, 3'd1, 1'b1, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h08, 5'b00010, 2'd0);
    add(1'b1, 3'd1, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h10, 5'b00000, 2'd0);
    add(1'b1, 3'd3, 1'b0, 5'b00000, 1'b1, 1'b0, 1'b0, 8'h02, 5'b00000, 2'd0);
    add(1'b1, 3'd3, 1'b0, 5'b00000, 1'b1, 1'b0, 1'b0, 8'h04, 5'b00000, 2'd0);
    add(1'b1, 3'd3, 1'b0, 5'b00000, 1'b1, 1'b0, 1'b0, 8'h08, 5'b01000, 2'd0);
    add(1'b1, 3'd2, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h20, 5'b00000, 2'd0);
    add(1'b1, 3'd2, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h02, 5'b00000, 2'd0);
    add(1'b1, 3'd2, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h04, 5'b00000, 2'd0);
    add(1'b1, 3'd2, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h08, 5'b00100, 2'd0);
    add(1'b1, 3'd2, 1'b0, 5'b10000, 1'b1, 1'b0, 1'b0, 8'h08, 5'b00100, 2'd0);
    add(1'b1, 3'd2, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h08, 5'b00100, 2'd0);
    add(1'b1, 3'd2, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h08, 5'b00100, 2'd0);
    add(1'b1, 3'd2, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h08, 5'b00100, 2'd0);
    add(1'b1, 3'd2, 1'b0, 5'b00100, 1'b0, 1'b0, 1'b0, 8'h08, 5'b00100, 2'd0);
    add(1'b1, 3'd2, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h10, 5'b00000, 2'd0);
    add(1'b1, 3'd0, 1'b1, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h02, 5'b00000, 2'd0);
    add(1'b1, 3'd0, 1'b1, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h04, 5'b00000, 2'd0);
    add(1'b1, 3'd0, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h40, 5'b00000, 2'd0);
    add(1'b1, 3'd0, 1'b0, 5'b00000, 1'b0, 1'b1, 1'b0, 8'h40, 5'b00000, 2'd0);
    add(1'b1, 3'd0, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h10, 5'b00000, 2'd0);
    add(1'b1, 3'd0, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h02, 5'b00000, 2'd0);
    add(1'b1, 3'd0, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h04, 5'b00000, 2'd0);
    add(1'b1, 3'd0, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h80, 5'b00000, 2'd1);
    add(1'b1, 3'd0, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b1, 8'h80, 5'b00000, 2'd1);
    add(1'b1, 3'd5, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h01, 5'b00000, 2'd0);
    add(1'b1, 3'd5, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h02, 5'b00000, 2'd0);
    add(1'b1, 3'd5, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h04, 5'b00000, 2'd0);
    add(1'b1, 3'd0, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b1, 8'h80, 5'b00000, 2'd1);
    add(1'b0, 3'd0, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 8'h01, 5'b00000, 2'd0);

    // Reset state
    repeat (2) tick();
    chk("rst.state", 32'(bus.state), 32'h01);
    chk("rst.outs", 32'({bus.fetch_req, bus.exec_en, bus.pc_inc, bus.pc_load, bus.fault, bus.fault_code}), 32'h0);
    chk("rst.cyc", bus.cyc_cnt, 32'h0);
    chk("rst.instr", bus.instr_cnt, 32'h0);
    rst = 1'b1;

    foreach (tbl[i]) begin
      bus.fetch_ack    = tbl[i].ack;
      bus.func         = tbl[i].func;
      bus.halt         = tbl[i].halt;
      bus.unit_done    = tbl[i].done;
      bus.branch_taken = tbl[i].br;
      bus.resume       = tbl[i].res;
      bus.fault_clr    = tbl[i].clr;
      exp_ctl = {tbl[i].st == 8'h80, tbl[i].st == 8'h20, tbl[i].st == 8'h10, tbl[i].st == 8'h02};
      act_ctl = {bus.fault, bus.pc_load, bus.pc_inc, bus.fetch_req};
      chk($sformatf("v%0d.state", i), 32'(bus.state), 32'(tbl[i].st));
      chk($sformatf("v%0d.exec_en", i), 32'(bus.exec_en), 32'(tbl[i].en));
      chk($sformatf("v%0d.ctl", i), 32'(act_ctl), 32'(exp_ctl));
      chk($sformatf("v%0d.code", i), 32'(bus.fault_code), 32'(tbl[i].code));
      tick();
    end

    // Fetch timeout: 200 FETCH cycles, then FAULT code 2
    quiet();
    n = 0;
    while (bus.state == 8'h02 && n < 300) begin
      n++;
      tick();
    end
    chk("ftmo.cycles", 32'(n), 32'd200);
    chk("ftmo.state", 32'(bus.state), 32'h80);
    chk("ftmo.code", 32'(bus.fault_code), 32'd2);
    chk("ftmo.fault", 32'(bus.fault), 32'd1);
    bus.fault_clr = 1'b1;
    tick();
    bus.fault_clr = 1'b0;
    chk("fclr.state", 32'(bus.state), 32'h01);
    chk("fclr.code", 32'(bus.fault_code), 32'd0);
    tick();
    repeat (199) tick();
    chk("flim.state", 32'(bus.state), 32'h02);
    bus.fetch_ack = 1'b1;
    tick();
    chk("flim.ack_wins", 32'(bus.state), 32'h04);
    chk("flim.fault", 32'(bus.fault), 32'd0);

    // Exec timeout on a handshaked unit that never completes
    bus.fetch_ack = 1'b0;
    bus.func      = 3'd2;
    tick();
    n = 0;
    while (bus.state == 8'h08 && n < 300) begin
      n++;
      tick();
    end
    chk("xtmo.cycles", 32'(n), 32'd200);
    chk("xtmo.state", 32'(bus.state), 32'h80);
    chk("xtmo.code", 32'(bus.fault_code), 32'd3);

    // Reset aborts FAULT
    #2 rst = 1'b0;
    #1;
    chk("rstf.state", 32'(bus.state), 32'h01);
    chk("rstf.code", 32'(bus.fault_code), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Done in the limit cycle wins over exec timeout
    bus.fetch_ack = 1'b1;
    bus.func      = 3'd2;
    repeat (3) tick();
    bus.fetch_ack = 1'b0;
    chk("xlim.enter", 32'(bus.state), 32'h08);
    repeat (199) tick();
    chk("xlim.still", 32'(bus.state), 32'h08);
    bus.unit_done = 5'b00100;
    tick();
    bus.unit_done = 5'b00000;
    chk("xlim.done_wins", 32'(bus.state), 32'h10);

    // Reset mid-EXEC
    bus.fetch_ack = 1'b1;
    repeat (3) tick();
    chk("rstx.pre", 32'(bus.state), 32'h08);
    #2 rst = 1'b0;
    #1;
    chk("rstx.state", 32'(bus.state), 32'h01);
    chk("rstx.exec_en", 32'(bus.exec_en), 32'h0);
    chk("rstx.cyc", bus.cyc_cnt, 32'h0);
    chk("rstx.instr", bus.instr_cnt, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Ten single-cycle instructions from reset
    bus.fetch_ack = 1'b1;
    bus.func      = 3'd1;
    repeat (41) tick();
    chk("perf.state", 32'(bus.state), 32'h02);
    chk("perf.instr", bus.instr_cnt, EXP_INSTR);
    chk("perf.cyc", bus.cyc_cnt, EXP_CYC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Parametrised, one-hot Moore control sequencer for the CPU control unit; successor to the fixed 5-function fetch/decode/execute FSM.
- Supports NUM_FUNC function units, each either single-cycle or handshaked (done-driven). Adds fetch handshake, per-wait timeout, branch PC load, halt/resume and a sticky fault state.
- Sits between instruction memory, decoder and the function units. Drives per-unit enables and PC control.

Parameters:
- NUM_FUNC, 5, number of function-block codes. Code 0 is reserved (special); legal execute codes are 1..NUM_FUNC-1.
- FUNC_W, 3, width of func. Requires NUM_FUNC <= 2**FUNC_W.
- MULTI_MASK, 5'b10100, bit i set = unit i waits for unit_done[i]; bit clear = unit i completes in one cycle.
- TMO_W, 8, timeout counter width.
- TMO_CYCLES, 200, wait cycles allowed in FETCH or EXEC before fault. Must be 1..2**TMO_W-1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- fetch_ack  in  1  instruction word valid this cycle
- func  in  FUNC_W  decoded function-block code, valid in DECODE
- halt  in  1  decoded halt, valid in DECODE
- unit_done  in  NUM_FUNC  per-unit completion
- branch_taken  in  1  branch resolved taken; sampled on the EXEC exit cycle
- resume  in  1  leave HALT
- fault_clr  in  1  leave FAULT
- state  out  8  one-hot current state
- fetch_req  out  1  instruction fetch request
- exec_en  out  NUM_FUNC  one-hot unit enable
- pc_inc  out  1  increment PC
- pc_load  out  1  load branch target into PC
- fault  out  1  in FAULT
- fault_code  out  2  0 none, 1 illegal func, 2 fetch timeout, 3 exec timeout
- cyc_cnt  out  32  active-cycle counter (optional feature)
- instr_cnt  out  32  retired-instruction counter (optional feature)

Behaviour:
- States, one-hot bit index: INIT 0, FETCH 1, DECODE 2, EXEC 3, INCPC 4, LOADPC 5, HALT 6, FAULT 7.
- While rst is low, asynchronously: state=INIT, func_q=0, timer=0, fault_code=0, counters=0. All outputs are 0 except state.
- All outputs are decoded from registered state only (pure Moore):
  - fetch_req = FETCH
  - exec_en[func_q] = EXEC
  - pc_inc = INCPC
  - pc_load = LOADPC
  - fault = FAULT
- INIT -> FETCH unconditionally.
- FETCH:
  - Remain while fetch_ack=0. On fetch_ack=1 -> DECODE.
- DECODE, in priority order:
  - halt=1 -> HALT.
  - Else func==0 or func>=NUM_FUNC -> FAULT, fault_code=1.
  - Else func_q<=func and -> EXEC.
- EXEC:
  - If MULTI_MASK[func_q]=0, exit after one cycle.
  - Otherwise remain until unit_done[func_q]=1; exit in that same cycle. unit_done bits of other units are ignored.
  - On exit: branch_taken=1 -> LOADPC, else -> INCPC.
- INCPC -> FETCH. LOADPC -> FETCH. Each lasts exactly one cycle.
- HALT:
  - Remain until resume=1, then -> INCPC (the halt instruction is retired).
  - halt input is ignored outside DECODE.
- FAULT:
  - Sticky. fault_code is held. fault_clr=1 -> INIT and fault_code<=0.
- Timeout:
  - timer clears on every state transition. It increments each cycle spent in FETCH or in a waiting EXEC, saturating at its maximum.
  - When timer==TMO_CYCLES-1 and there is no ack/done that cycle -> FAULT, with code 2 (FETCH) or 3 (EXEC).
  - Ack/done in the limit cycle wins over timeout.
- Minimum instruction latency, single-cycle unit with immediate ack: FETCH, DECODE, EXEC, INCPC = 4 cycles.
- Reset asserted mid-operation aborts immediately, including HALT and FAULT.
- An illegal one-hot state (not reachable in normal operation) -> INIT next cycle.

Optional Feature:
- Macro SEQ_PERF_CNT_EN.
- Defined:
  - cyc_cnt increments every cycle the state is not INIT, HALT or FAULT.
  - instr_cnt increments every cycle in INCPC or LOADPC.
  - Both are 32-bit and wrap modulo 2**32. Both clear on reset only (not on fault_clr).
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- Reset release, fetch_ack=1 constant, func=1 (single-cycle): state sequence 01,02,04,08,10,02,... repeats. exec_en=5'b00010 for exactly one cycle per instruction.
- func=2 (multi), unit_done[2] asserted 5 cycles into EXEC, unit_done[4] pulsed earlier: EXEC lasts 6 cycles. unit_done[4] is ignored. -> INCPC.
- func=3, branch_taken=1 at EXEC exit: state 08 -> 20 (pc_load=1, pc_inc=0) -> 02.
- fetch_ack held 0, TMO_CYCLES=200: FAULT after 200 FETCH cycles with fault_code=2. fault_clr -> INIT, fault_code=0. Repeat with ack in cycle 200 -> DECODE, no fault.
- DECODE with func=0, halt=0 -> FAULT, code 1. DECODE with halt=1, func=0 -> HALT. resume -> INCPC -> FETCH.
- With SEQ_PERF_CNT_EN: 10 single-cycle instructions after reset give instr_cnt=10 and cyc_cnt=40 at the 10th INCPC exit. rst low mid-EXEC zeroes both immediately, state=01.
